// File: rtl/alu_vector.sv
// Vector ALU: one opcode applied across LANES lanes of WIDTH bits, registered result with per-lane flags.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for divide (iterative restoring, all lanes in parallel).
// Backpressure: valid/ready on both sides; result held while out_ready is low, input stalls when the result slot is full or dividing.
module alu_vector #(
    parameter int WIDTH = 16,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   A,
    input  logic [LANES*WIDTH-1:0]   B,
    input  logic [2:0]               sel,
    input  logic [LANES-1:0]         mask,
    output logic [LANES*WIDTH-1:0]   C,
    output logic [LANES-1:0]         flagZ,
    output logic [LANES-1:0]         flagN,
    output logic [LANES-1:0]         flagDZ,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int               LW      = LANES * WIDTH;
    localparam int               CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [2:0]       OP_ADD  = 3'b000;
    localparam logic [2:0]       OP_SUB  = 3'b001;
    localparam logic [2:0]       OP_MUL  = 3'b010;
    localparam logic [2:0]       OP_DIV  = 3'b011;
    localparam logic [2:0]       OP_SRA  = 3'b100;
    localparam logic [2:0]       OP_SRL  = 3'b101;
    localparam logic [2:0]       OP_SLL  = 3'b110;
    localparam logic [2:0]       OP_AND  = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } state_t;

    // Control and output registers
    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               out_valid_q;
    logic [LW-1:0]      c_q;
    logic [LANES-1:0]   z_q;
    logic [LANES-1:0]   n_q;
    logic [LANES-1:0]   dz_q;

    // Divider operand latches and working registers
    logic [LW-1:0]      a_q;
    logic [LW-1:0]      b_q;
    logic [LANES-1:0]   mask_q;
    logic [LW-1:0]      rem_q;
    logic [LW-1:0]      quo_q;

    // Combinational next values
    logic [LW-1:0]      rem_d;
    logic [LW-1:0]      quo_d;
    logic [WIDTH:0]     trial [LANES];
    logic [LANES-1:0]   ge;

    logic [LW-1:0]      alu_c;
    logic [LANES-1:0]   alu_n;
    logic [LW-1:0]      div_c;
    logic [LANES-1:0]   div_n;
    logic [LANES-1:0]   div_dz;

    logic [LW-1:0]      ld_c_d;
    logic [LANES-1:0]   ld_z_d;
    logic [LANES-1:0]   ld_n_d;
    logic [LANES-1:0]   ld_dz_d;

    logic               accept;

    // One lane of the single-cycle operations; the shift amount is the whole of b,
    // so amounts of WIDTH or more saturate instead of wrapping.
    function automatic logic [WIDTH-1:0] lane_op(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       op
    );
        logic [WIDTH-1:0] res;
        logic             big;
        big = (b >= WIDTH_V);
        res = '0;
        case (op)
            OP_ADD: res = a + b;
            OP_SUB: res = a - b;
            OP_MUL: res = a * b;
            OP_SRA: begin
                if (big) res = {WIDTH{a[WIDTH-1]}};
                else     res = $signed(a) >>> b;
            end
            OP_SRL: begin
                if (big) res = '0;
                else     res = a >> b;
            end
            OP_SLL: begin
                if (big) res = '0;
                else     res = a << b;
            end
            OP_AND: res = a & b;
            default: res = '0;
        endcase
        return res;
    endfunction

    // Handshake: the result slot is free when empty or being drained this cycle.
    always_comb begin
        in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
    end

    // Single-cycle datapath on the live inputs; masked lanes pass A through.
    always_comb begin
        alu_c = '0;
        alu_n = '0;
        for (int i = 0; i < LANES; i++) begin
            alu_c[i*WIDTH +: WIDTH] = mask[i] ? lane_op(A[i*WIDTH +: WIDTH], B[i*WIDTH +: WIDTH], sel)
                                              : A[i*WIDTH +: WIDTH];
            alu_n[i] = A[i*WIDTH +: WIDTH] < B[i*WIDTH +: WIDTH];
        end
    end

    // One restoring-division step per lane: shift the next dividend bit into the
    // partial remainder and subtract the divisor when it fits.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        ge    = '0;
        trial = '{default: '0};
        for (int i = 0; i < LANES; i++) begin
            trial[i] = {rem_q[i*WIDTH +: WIDTH], quo_q[i*WIDTH + WIDTH - 1]};
            ge[i]    = trial[i] >= {1'b0, b_q[i*WIDTH +: WIDTH]};
            rem_d[i*WIDTH +: WIDTH] = ge[i] ? WIDTH'(trial[i] - {1'b0, b_q[i*WIDTH +: WIDTH]})
                                            : trial[i][WIDTH-1:0];
            quo_d[i*WIDTH +: WIDTH] = {quo_q[i*WIDTH +: WIDTH-1], ge[i]};
        end
    end

    // Divide result, taken from the final step; a zero divisor forces all ones.
    always_comb begin
        div_c  = '0;
        div_n  = '0;
        div_dz = '0;
        for (int i = 0; i < LANES; i++) begin
            div_dz[i] = mask_q[i] && (b_q[i*WIDTH +: WIDTH] == '0);
            if (!mask_q[i])
                div_c[i*WIDTH +: WIDTH] = a_q[i*WIDTH +: WIDTH];
            else if (b_q[i*WIDTH +: WIDTH] == '0)
                div_c[i*WIDTH +: WIDTH] = '1;
            else
                div_c[i*WIDTH +: WIDTH] = quo_d[i*WIDTH +: WIDTH];
            div_n[i] = a_q[i*WIDTH +: WIDTH] < b_q[i*WIDTH +: WIDTH];
        end
    end

    // Select which datapath feeds the output registers and derive the zero flags.
    always_comb begin
        ld_c_d  = (state_q == S_DIV) ? div_c  : alu_c;
        ld_n_d  = (state_q == S_DIV) ? div_n  : alu_n;
        ld_dz_d = (state_q == S_DIV) ? div_dz : '0;
        ld_z_d  = '0;
        for (int i = 0; i < LANES; i++) begin
            ld_z_d[i] = (ld_c_d[i*WIDTH +: WIDTH] == '0);
        end
    end

    // Control FSM, divider iteration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            z_q         <= '0;
            n_q         <= '0;
            dz_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mask_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (sel == OP_DIV) begin
                            a_q     <= A;
                            b_q     <= B;
                            mask_q  <= mask;
                            rem_q   <= '0;
                            quo_q   <= A;
                            cnt_q   <= CW'(WIDTH - 1);
                            state_q <= S_DIV;
                        end else begin
                            c_q         <= ld_c_d;
                            z_q         <= ld_z_d;
                            n_q         <= ld_n_d;
                            dz_q        <= ld_dz_d;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    if (cnt_q != '0) begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - CW'(1);
                    end else if (!out_valid_q || out_ready) begin
                        // Last quotient bit is folded into the load; the working
                        // registers are left untouched while waiting so it can be recomputed.
                        c_q         <= ld_c_d;
                        z_q         <= ld_z_d;
                        n_q         <= ld_n_d;
                        dz_q        <= ld_dz_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign C         = c_q;
    assign flagZ     = z_q;
    assign flagN     = n_q;
    assign flagDZ    = dz_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_vector.sv
// Testbench for alu_vector: directed test-plan steps plus randomized ops against a lane-level arithmetic model.
// Latency is counted in clock edges from the accepting edge (inclusive) to out_valid.
// Backpressure is exercised with a stalled consumer and a small in-order scoreboard.
module tb_alu_vector;

    localparam int W = 16;
    localparam int L = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   A;
    logic [63:0]   B;
    logic [2:0]    sel;
    logic [3:0]    mask;
    logic [63:0]   C;
    logic [3:0]    flagZ;
    logic [3:0]    flagN;
    logic [3:0]    flagDZ;
    logic          out_valid;
    logic          out_ready;

    int            checks = 0;
    int            errors = 0;

    logic [63:0]   got_c;
    logic [3:0]    got_z;
    logic [3:0]    got_n;
    logic [3:0]    got_dz;
    int            got_lat;

    always #5 clk = ~clk;

    alu_vector #(.WIDTH(W), .LANES(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sel       (sel),
        .mask      (mask),
        .C         (C),
        .flagZ     (flagZ),
        .flagN     (flagN),
        .flagDZ    (flagDZ),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic for one 16-bit lane, written with plain integers.
    function automatic int model(input int a, input int b, input int op);
        int     r;
        int     sa;
        longint p;
        r = 0;
        case (op)
            0: r = (a + b) & 16'hFFFF;
            1: r = (a - b) & 16'hFFFF;
            2: begin p = longint'(a) * longint'(b); r = int'(p & 64'hFFFF); end
            3: r = (b == 0) ? 16'hFFFF : a / b;
            4: begin
                sa = (a >= 32768) ? a - 65536 : a;
                if (b >= 16) r = (sa < 0) ? 16'hFFFF : 0;
                else         r = (sa >>> b) & 16'hFFFF;
            end
            5: r = (b >= 16) ? 0 : (a >> b);
            6: r = (b >= 16) ? 0 : ((a << b) & 16'hFFFF);
            7: r = a & b;
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic void expect_vec(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                                       input logic [3:0] m, output logic [63:0] ec, output logic [3:0] ez,
                                       output logic [3:0] en, output logic [3:0] edz);
        int av;
        int bv;
        int rv;
        ec = '0; ez = '0; en = '0; edz = '0;
        for (int i = 0; i < L; i++) begin
            av = int'(a[i*W +: W]);
            bv = int'(b[i*W +: W]);
            rv = m[i] ? model(av, bv, int'(op)) : av;
            ec[i*W +: W] = rv[15:0];
            ez[i]  = (rv == 0);
            en[i]  = (av < bv);
            edz[i] = m[i] && (op == 3'b011) && (bv == 0);
        end
    endfunction

    // Issue one beat, wait for its result with out_ready high, and check it against the model.
    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] op, input logic [3:0] m);
        logic [63:0] ec;
        logic [3:0]  ez, en, edz;
        int          lat;
        int          waited;
        bit          rdy_seen;
        expect_vec(a, b, op, m, ec, ez, en, edz);
        @(negedge clk);
        A = a; B = b; sel = op; mask = m; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk); #1; waited++;
        end
        if (!in_ready) begin
            check({tag, "_accept"}, 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        // Scramble the inputs: they must only be sampled on acceptance.
        in_valid = 1'b0;
        A = {$urandom, $urandom}; B = {$urandom, $urandom}; sel = 3'($urandom); mask = 4'($urandom);
        #1;
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_seen = 1'b1;
            @(negedge clk); #1; lat++;
        end
        got_c = C; got_z = flagZ; got_n = flagN; got_dz = flagDZ; got_lat = lat;
        check({tag, "_lat"}, 64'(lat), (op == 3'b011) ? 64'd17 : 64'd1);
        if (op == 3'b011) check({tag, "_rdy_in_div"}, 64'(rdy_seen), 64'd0);
        check({tag, "_c"},  got_c,       ec);
        check({tag, "_z"},  64'(got_z),  64'(ez));
        check({tag, "_n"},  64'(got_n),  64'(en));
        check({tag, "_dz"}, 64'(got_dz), 64'(edz));
    endtask

    initial begin : main
        logic [63:0] ra, rb;
        logic [63:0] ec;
        logic [3:0]  ez, en, edz;
        logic [63:0] q[$];
        logic [63:0] ba [3];
        logic [63:0] bb [3];
        int          sent, recv, k;
        bit          seen;

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; sel = '0; mask = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_c",         C,              64'd0);
        check("rst_flags",     64'({flagZ, flagN, flagDZ}), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);

        // Add wrap
        do_op("add_wrap", 64'hFFFF_0001_1234_0000, 64'h0001_0001_0000_0000, 3'b000, 4'b1111);
        check("tp_add_c", got_c,       64'h0000_0002_1234_0000);
        check("tp_add_z", 64'(got_z),  64'b1001);
        check("tp_add_n", 64'(got_n),  64'b0000);

        // Divide with one zero divisor
        do_op("div", 64'h0064_0007_8000_0005, 64'h000A_0002_0000_0005, 3'b011, 4'b1111);
        check("tp_div_c",   got_c,       64'h000A_0003_FFFF_0001);
        check("tp_div_dz",  64'(got_dz), 64'b0010);
        check("tp_div_lat", 64'(got_lat), 64'd17);

        // Shift boundaries
        do_op("sra4", {4{16'h8000}}, {4{16'h0004}}, 3'b100, 4'b1111);
        check("tp_sra4", got_c, {4{16'hF800}});
        do_op("sra16", {4{16'h8000}}, {4{16'h0010}}, 3'b100, 4'b1111);
        check("tp_sra16", got_c, {4{16'hFFFF}});
        do_op("srl16", {4{16'h8000}}, {4{16'h0010}}, 3'b101, 4'b1111);
        check("tp_srl16", got_c, 64'd0);
        do_op("sll1", {4{16'h8000}}, {4{16'h0001}}, 3'b110, 4'b1111);
        check("tp_sll1_c", got_c, 64'd0);
        check("tp_sll1_z", 64'(got_z), 64'b1111);

        // Mask on subtract
        do_op("mask_sub", {4{16'h0005}}, {4{16'h0007}}, 3'b001, 4'b0101);
        check("tp_mask_c",  got_c,       64'h0005_FFFE_0005_FFFE);
        check("tp_mask_n",  64'(got_n),  64'b1111);
        check("tp_mask_dz", 64'(got_dz), 64'b0000);

        // Masked divide lanes never flag divide-by-zero
        do_op("div_masked", 64'h1111_2222_3333_4444, 64'h0000_0000_0003_0000, 3'b011, 4'b0110);

        // Randomized ops, divisors and shift amounts biased toward interesting values
        for (int t = 0; t < 60; t++) begin
            ra = {$urandom, $urandom};
            rb = '0;
            for (int i = 0; i < L; i++) begin
                case ($urandom_range(0, 3))
                    0:       rb[i*W +: W] = 16'h0000;
                    1:       rb[i*W +: W] = 16'($urandom_range(0, 20));
                    default: rb[i*W +: W] = 16'($urandom);
                endcase
            end
            do_op("rnd", ra, rb, 3'($urandom_range(0, 7)), 4'($urandom));
        end

        // Backpressure: three back-to-back adds, consumer stalled for four cycles
        for (int j = 0; j < 3; j++) begin
            ba[j] = {$urandom, $urandom};
            bb[j] = {$urandom, $urandom};
        end
        sent = 0; recv = 0; k = 0;
        while ((sent < 3 || recv < 3) && k < 30) begin
            @(negedge clk);
            out_ready = (k >= 4);
            in_valid  = (sent < 3);
            if (sent < 3) begin
                A = ba[sent]; B = bb[sent]; sel = 3'b000; mask = 4'b1111;
            end
            #1;
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("bp_extra_result", 64'd1, 64'd0);
                end else begin
                    check("bp_c", C, q[0]);
                    if (!out_ready) check("bp_stall_in_ready", 64'(in_ready), 64'd0);
                    if (out_ready) begin
                        void'(q.pop_front());
                        recv++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                expect_vec(A, B, 3'b000, 4'b1111, ec, ez, en, edz);
                q.push_back(ec);
                sent++;
            end
            k++;
        end
        check("bp_recv", 64'(recv), 64'd3);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("bp_drained", 64'(out_valid), 64'd0);

        // Reset in the middle of a divide
        @(negedge clk);
        A = 64'h7FFF_1234_0100_00FF; B = 64'h0003_0010_0000_0007; sel = 3'b011; mask = 4'b1111;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("rdiv_accept", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rdiv_out_valid", 64'(out_valid), 64'd0);
        check("rdiv_c",         C,              64'd0);
        check("rdiv_flags",     64'({flagZ, flagN, flagDZ}), 64'd0);
        check("rdiv_in_ready",  64'(in_ready),  64'd1);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("rdiv_no_result", 64'(seen), 64'd0);
        do_op("post_rst_add", 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 3'b000, 4'b1111);
        check("post_rst_lat", 64'(got_lat), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench never hangs.
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_vector.md
Name: alu_vector

Overview:
- Parametrised, handshaked successor to the team's scalar ALU.
- Applies one operation across LANES independent lanes of WIDTH bits and registers the result with per-lane Z/N flags.
- All operations are single-cycle, except division, which runs an iterative restoring divider over all lanes in parallel.
- Sits between the vector register file read stage and writeback of the vector datapath.

Parameters:
- WIDTH, 16, bits per lane element.
- LANES, 4, number of parallel lanes.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op beat present.
- in_ready  output  1  block can accept a beat this cycle.
- A  input  LANES*WIDTH  operand A; lane i at bits [i*WIDTH +: WIDTH].
- B  input  LANES*WIDTH  operand B; same packing as A.
- sel  input  3  operation code.
- mask  input  LANES  lane enable; a 0 bit makes that lane pass A through.
- C  output  LANES*WIDTH  registered result.
- flagZ  output  LANES  per-lane result == 0.
- flagN  output  LANES  per-lane A < B, unsigned compare on accepted operands.
- flagDZ  output  LANES  per-lane divide-by-zero; set only for sel=011 on enabled lanes.
- out_valid  output  1  C and flags are valid.
- out_ready  input  1  consumer takes the result.

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - C and flags are held stable while out_valid && !out_ready.
- Opcodes (sel), per enabled lane, result truncated to WIDTH bits:
  - 000 A+B (wraps).
  - 001 A-B (wraps).
  - 010 low WIDTH bits of A*B.
  - 011 unsigned A/B.
  - 100 arithmetic right shift: A treated as signed, sign fill.
  - 101 logical right shift.
  - 110 logical left shift.
  - 111 A&B.
- Shift amount is the full unsigned B.
  - B >= WIDTH on a logical shift gives 0.
  - B >= WIDTH on an arithmetic shift gives all sign bits.
- Masked lane (mask[i]=0):
  - C lane = A lane; flagZ computed on that value.
  - flagN still computed.
  - flagDZ = 0.
- Division by zero on an enabled lane: quotient = all ones, flagDZ[i] = 1. Other lanes are unaffected.
- State machine (IDLE, DIV):
  - IDLE: in_ready = !out_valid || out_ready.
    - Accepted non-divide beat: result registered, out_valid = 1 next cycle. Latency 1; back-to-back throughput 1 per cycle.
    - Accepted divide beat: operands latched, counter = WIDTH-1, go to DIV.
  - DIV: in_ready = 0. One quotient bit per lane per cycle.
    - When counter == 0 and (!out_valid || out_ready): load the result, set out_valid, return to IDLE.
    - Otherwise, at counter == 0, wait in DIV.
    - Divide latency is WIDTH+1 cycles from acceptance to out_valid, with no backpressure.
- A simultaneous output transfer and new input acceptance in IDLE is legal; out_valid stays 1 with the new result.
- Reset:
  - out_valid = 0, C = 0, flagZ = 0, flagN = 0, flagDZ = 0.
  - State = IDLE, counter = 0, in_ready = 1 in the cycle after reset.
  - Reset asserted mid-divide aborts the operation; no result is emitted.
- Inputs are ignored when in_valid is 0 or in_ready is 0. sel, A, B and mask are sampled only on acceptance.

Test Plan:
- Add wrap, WIDTH=16, LANES=4, sel=000:
  - Stimulus: A = {FFFF, 0001, 1234, 0000}, B = {0001, 0001, 0000, 0000}, mask = 1111.
  - Response: after 1 cycle, C = {0000, 0002, 1234, 0000}, flagZ = 1001, flagN = 0000.
- Divide with a zero divisor, sel=011:
  - Stimulus: A = {0064, 0007, 8000, 0005}, B = {000A, 0002, 0000, 0005}.
  - Response: out_valid 17 cycles after acceptance; C = {000A, 0003, FFFF, 0001}, flagDZ = 0010; in_ready = 0 throughout DIV.
- Shift boundaries, A = 8000 in all lanes:
  - sel=100, B = 0004 → F800.
  - sel=100, B = 0010 → FFFF.
  - sel=101, B = 0010 → 0000.
  - sel=110, B = 0001 → 0000, flagZ set.
- Mask, sel=001:
  - Stimulus: A = 5, B = 7 in all lanes, mask = 0101.
  - Response: enabled lanes give FFFE; masked lanes give 0005; flagN = 1111; flagDZ = 0000.
- Backpressure:
  - Stimulus: 3 back-to-back adds with out_ready = 0 for 4 cycles, then 1.
  - Response: first result held stable; in_ready = 0 while stalled; all 3 results emerge in order with no loss or duplication.
- Reset mid-divide:
  - Stimulus: assert rst for 1 cycle, 5 cycles into a divide.
  - Response: next cycle out_valid = 0, all outputs 0, in_ready = 1; the next add completes with latency 1.
